lcd_timing_gen: RTL and testbench

//  Parametrised, synthesisable LCD/MTL raster timing generator for the LCD clock domain.

---
 rtl/lcd_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// LCD/MTL raster timing generator: sync, data-enable, coordinates, prefetch request,
// frame markers and a completed-frame counter, all registered in the pixel clock domain.
module lcd_timing_gen #(
    parameter int unsigned H_TOTAL     = 1056,
    parameter int unsigned H_SYNC      = 30,
    parameter int unsigned H_ACT_START = 50,
    parameter int unsigned H_ACT       = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 3,
    parameter int unsigned V_ACT_START = 23,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned SYNC_POL    = 0,
    parameter int unsigned PREFETCH    = 2,
    parameter int unsigned FCNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    output logic              o_hsd,
    output logic              o_vsd,
    output logic              o_de,
    output logic [10:0]       o_x,
    output logic [9:0]        o_y,
    output logic              o_req,
    output logic [10:0]       o_req_x,
    output logic [9:0]        o_req_y,
    output logic              o_sof,
    output logic              o_vbl,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    localparam int unsigned HW  = 11;
    localparam int unsigned VW  = 10;
    localparam int unsigned HEW = HW + 1;
    localparam int unsigned VEW = VW + 1;
    localparam int unsigned H_ACT_END = H_ACT_START + H_ACT;
    localparam int unsigned V_ACT_END = V_ACT_START + V_ACT;
    // Pin level of an inactive sync output.
    localparam logic SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

    // Geometry sanity checks at elaboration.
    if (!(H_SYNC < H_ACT_START)) begin : g_bad_hsync
        $error("lcd_timing_gen: H_SYNC must be below H_ACT_START");
    end
    if (!(H_ACT_END <= H_TOTAL)) begin : g_bad_hact
        $error("lcd_timing_gen: horizontal active window exceeds H_TOTAL");
    end
    if (!(V_ACT_END <= V_TOTAL)) begin : g_bad_vact
        $error("lcd_timing_gen: vertical active window exceeds V_TOTAL");
    end
    if (!(PREFETCH <= H_ACT_START)) begin : g_bad_prefetch
        $error("lcd_timing_gen: PREFETCH must not exceed H_ACT_START");
    end
    if (!(H_TOTAL <= 2048)) begin : g_bad_htotal
        $error("lcd_timing_gen: H_TOTAL must not exceed 2048");
    end
    if (!(V_TOTAL <= 1024)) begin : g_bad_vtotal
        $error("lcd_timing_gen: V_TOTAL must not exceed 1024");
    end

    logic [HW-1:0]  h_q;
    logic [VW-1:0]  v_q;
    logic           started_q;

    logic [HW-1:0]  h_nxt;
    logic [VW-1:0]  v_nxt;
    logic [HEW-1:0] h_ext;
    logic [HEW-1:0] hp_ext;
    logic [VEW-1:0] v_ext;
    logic           h_in;
    logic           hp_in;
    logic           v_in;
    logic           de_nxt;
    logic           req_nxt;
    logic [HW-1:0]  x_nxt;
    logic [VW-1:0]  y_nxt;
    logic [HW-1:0]  req_x_nxt;
    logic [VW-1:0]  req_y_nxt;
    logic           hsd_nxt;
    logic           vsd_nxt;
    logic           origin_nxt;
    logic           vbl_nxt;

    // Next raster position: h wraps at end of line, v advances on h wrap.
    always_comb begin
        h_nxt = h_q + HW'(1);
        v_nxt = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_nxt = '0;
            v_nxt = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    // Output values for the next position; widened to avoid window-end overflow.
    always_comb begin
        h_ext      = HEW'(h_nxt);
        hp_ext     = HEW'(h_nxt) + HEW'(PREFETCH);
        v_ext      = VEW'(v_nxt);
        h_in       = (h_ext >= HEW'(H_ACT_START)) && (h_ext < HEW'(H_ACT_END));
        hp_in      = (hp_ext >= HEW'(H_ACT_START)) && (hp_ext < HEW'(H_ACT_END));
        v_in       = (v_ext >= VEW'(V_ACT_START)) && (v_ext < VEW'(V_ACT_END));
        de_nxt     = h_in && v_in;
        req_nxt    = hp_in && v_in;
        x_nxt      = '0;
        y_nxt      = '0;
        req_x_nxt  = '0;
        req_y_nxt  = '0;
        if (de_nxt) begin
            x_nxt = HW'(h_ext - HEW'(H_ACT_START));
            y_nxt = VW'(v_ext - VEW'(V_ACT_START));
        end
        if (req_nxt) begin
            req_x_nxt = HW'(hp_ext - HEW'(H_ACT_START));
            req_y_nxt = VW'(v_ext - VEW'(V_ACT_START));
        end
        hsd_nxt    = (h_ext < HEW'(H_SYNC)) ^ SYNC_IDLE;
        vsd_nxt    = (v_ext < VEW'(V_SYNC)) ^ SYNC_IDLE;
        origin_nxt = (h_nxt == '0) && (v_nxt == '0);
        vbl_nxt    = (h_nxt == '0) && (v_ext == VEW'(V_ACT_END));
    end

    // Position and registered outputs; frozen (pulses cleared) while i_en is low.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            h_q         <= HW'(H_TOTAL - 1);
            v_q         <= VW'(V_TOTAL - 1);
            started_q   <= 1'b0;
            o_hsd       <= SYNC_IDLE;
            o_vsd       <= SYNC_IDLE;
            o_de        <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_req       <= 1'b0;
            o_req_x     <= '0;
            o_req_y     <= '0;
            o_sof       <= 1'b0;
            o_vbl       <= 1'b0;
            o_frame_cnt <= '0;
        end else if (i_en) begin
            h_q     <= h_nxt;
            v_q     <= v_nxt;
            o_hsd   <= hsd_nxt;
            o_vsd   <= vsd_nxt;
            o_de    <= de_nxt;
            o_x     <= x_nxt;
            o_y     <= y_nxt;
            o_req   <= req_nxt;
            o_req_x <= req_x_nxt;
            o_req_y <= req_y_nxt;
            o_sof   <= origin_nxt;
            o_vbl   <= vbl_nxt;
            if (origin_nxt) begin
                started_q <= 1'b1;
                if (started_q) begin
                    o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
                end
            end
        end else begin
            o_sof <= 1'b0;
            o_vbl <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: three geometries against a position-based model plus directed literals.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

    typedef struct packed {
        int unsigned ht, hs, has, ha, vt, vs, vas, va, pol, pf, fw;
    } geom_t;

    typedef struct {
        int hsd, vsd, de, x, y, req, rx, ry, sof, vbl, cnt;
    } exp_t;

    typedef struct {
        int x, y, t;
    } pend_t;

    localparam int unsigned B_HT = 16, B_HS = 2, B_HAS = 4, B_HA = 8;
    localparam int unsigned B_VT = 8, B_VS = 1, B_VAS = 2, B_VA = 4;
    localparam int unsigned B_POL = 1, B_PF = 4, B_FW = 16;
    localparam int unsigned C_HT = 8, C_HS = 1, C_HAS = 2, C_HA = 4;
    localparam int unsigned C_VT = 4, C_VS = 1, C_VAS = 1, C_VA = 2;
    localparam int unsigned C_POL = 0, C_PF = 0, C_FW = 2;

    localparam geom_t GA = '{ht:1056, hs:30, has:50, ha:800, vt:525, vs:3, vas:23, va:480,
                             pol:0, pf:2, fw:16};
    localparam geom_t GB = '{ht:B_HT, hs:B_HS, has:B_HAS, ha:B_HA, vt:B_VT, vs:B_VS,
                             vas:B_VAS, va:B_VA, pol:B_POL, pf:B_PF, fw:B_FW};
    localparam geom_t GC = '{ht:C_HT, hs:C_HS, has:C_HAS, ha:C_HA, vt:C_VT, vs:C_VS,
                             vas:C_VAS, va:C_VA, pol:C_POL, pf:C_PF, fw:C_FW};

    logic        clk;
    logic [2:0]  rstn;
    logic [2:0]  en;
    logic        hsd [3];
    logic        vsd [3];
    logic        de  [3];
    logic        req [3];
    logic        sof [3];
    logic        vbl [3];
    logic [10:0] ox  [3];
    logic [9:0]  oy  [3];
    logic [10:0] rx  [3];
    logic [9:0]  ry  [3];
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [1:0]  cnt_c;

    lcd_timing_gen u_a (
        .i_clk(clk), .i_rstn(rstn[0]), .i_en(en[0]),
        .o_hsd(hsd[0]), .o_vsd(vsd[0]), .o_de(de[0]), .o_x(ox[0]), .o_y(oy[0]),
        .o_req(req[0]), .o_req_x(rx[0]), .o_req_y(ry[0]),
        .o_sof(sof[0]), .o_vbl(vbl[0]), .o_frame_cnt(cnt_a)
    );

    lcd_timing_gen #(
        .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_ACT_START(B_HAS), .H_ACT(B_HA),
        .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_ACT_START(B_VAS), .V_ACT(B_VA),
        .SYNC_POL(B_POL), .PREFETCH(B_PF), .FCNT_W(B_FW)
    ) u_b (
        .i_clk(clk), .i_rstn(rstn[1]), .i_en(en[1]),
        .o_hsd(hsd[1]), .o_vsd(vsd[1]), .o_de(de[1]), .o_x(ox[1]), .o_y(oy[1]),
        .o_req(req[1]), .o_req_x(rx[1]), .o_req_y(ry[1]),
        .o_sof(sof[1]), .o_vbl(vbl[1]), .o_frame_cnt(cnt_b)
    );

    lcd_timing_gen #(
        .H_TOTAL(C_HT), .H_SYNC(C_HS), .H_ACT_START(C_HAS), .H_ACT(C_HA),
        .V_TOTAL(C_VT), .V_SYNC(C_VS), .V_ACT_START(C_VAS), .V_ACT(C_VA),
        .SYNC_POL(C_POL), .PREFETCH(C_PF), .FCNT_W(C_FW)
    ) u_c (
        .i_clk(clk), .i_rstn(rstn[2]), .i_en(en[2]),
        .o_hsd(hsd[2]), .o_vsd(vsd[2]), .o_de(de[2]), .o_x(ox[2]), .o_y(oy[2]),
        .o_req(req[2]), .o_req_x(rx[2]), .o_req_y(ry[2]),
        .o_sof(sof[2]), .o_vbl(vbl[2]), .o_frame_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: raster position, freshness since reset, and completed frames.
    int mh [3];
    int mv [3];
    bit madv [3];
    bit mfresh [3];
    bit mstart [3];
    int mcnt [3];
    int mae [3];

    int n_tests;
    int n_fail;
    int now;
    bit go;

    pend_t pq[$];
    int    npairs;
    bit    hprev;
    bit    have_fall;
    int    last_fall;
    int    froz;
    int    csof_t[$];
    int    csof_c[$];

    function automatic geom_t g_of(input int k);
        case (k)
            0:       return GA;
            1:       return GB;
            default: return GC;
        endcase
    endfunction

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    // What the pins must show at position (h,v) from the raster rules.
    function automatic exp_t model_out(input geom_t g, input int h, input int v,
                                       input bit fresh, input bit adv, input int cnt);
        exp_t e;
        int   hp;
        bit   vin;
        bit   hin;
        bit   hpin;
        e.hsd = (g.pol == 0) ? 1 : 0;
        e.vsd = e.hsd;
        e.de = 0; e.x = 0; e.y = 0; e.req = 0; e.rx = 0; e.ry = 0;
        e.sof = 0; e.vbl = 0; e.cnt = 0;
        if (!fresh) begin
            e.hsd = ((h < int'(g.hs)) == (g.pol == 1)) ? 1 : 0;
            e.vsd = ((v < int'(g.vs)) == (g.pol == 1)) ? 1 : 0;
            hp   = h + int'(g.pf);
            vin  = (v >= int'(g.vas)) && (v < int'(g.vas + g.va));
            hin  = (h >= int'(g.has)) && (h < int'(g.has + g.ha));
            hpin = (hp >= int'(g.has)) && (hp < int'(g.has + g.ha));
            if (hin && vin) begin
                e.de = 1; e.x = h - int'(g.has); e.y = v - int'(g.vas);
            end
            if (hpin && vin) begin
                e.req = 1; e.rx = hp - int'(g.has); e.ry = v - int'(g.vas);
            end
            e.sof = (adv && h == 0 && v == 0) ? 1 : 0;
            e.vbl = (adv && h == 0 && v == int'(g.vas + g.va)) ? 1 : 0;
            e.cnt = cnt & ((1 << g.fw) - 1);
        end
        return e;
    endfunction

    // Advance the model raster on each clock edge.
    always @(posedge clk) begin : model
        geom_t g;
        for (int k = 0; k < 3; k++) begin
            g = g_of(k);
            if (!rstn[k]) begin
                mh[k] = int'(g.ht) - 1; mv[k] = int'(g.vt) - 1;
                madv[k] = 0; mfresh[k] = 1; mstart[k] = 0; mcnt[k] = 0; mae[k] = 0;
            end else if (en[k]) begin
                mh[k]++;
                if (mh[k] == int'(g.ht)) begin
                    mh[k] = 0;
                    mv[k]++;
                    if (mv[k] == int'(g.vt)) mv[k] = 0;
                end
                if (mh[k] == 0 && mv[k] == 0) begin
                    if (mstart[k]) mcnt[k]++;
                    mstart[k] = 1;
                end
                madv[k] = 1; mfresh[k] = 0; mae[k]++;
            end else begin
                madv[k] = 0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d at cycle %0d: got %0d expected %0d", nm, k, now, act, expv);
        end
    endtask

    // Per-cycle model compare plus request/enable pairing, line period and frame log.
    task automatic per_cycle();
        exp_t  e;
        pend_t p;
        for (int k = 0; k < 3; k++) begin
            e = model_out(g_of(k), mh[k], mv[k], mfresh[k] || !rstn[k], madv[k], mcnt[k]);
            chk("hsd", k, int'(hsd[k]), e.hsd);
            chk("vsd", k, int'(vsd[k]), e.vsd);
            chk("de", k, int'(de[k]), e.de);
            chk("x", k, int'(ox[k]), e.x);
            chk("y", k, int'(oy[k]), e.y);
            chk("req", k, int'(req[k]), e.req);
            chk("req_x", k, int'(rx[k]), e.rx);
            chk("req_y", k, int'(ry[k]), e.ry);
            chk("sof", k, int'(sof[k]), e.sof);
            chk("vbl", k, int'(vbl[k]), e.vbl);
            chk("frame_cnt", k, cnt_of(k), e.cnt);
        end
        if (madv[0]) begin
            if (req[0]) begin
                p.x = int'(rx[0]); p.y = int'(ry[0]); p.t = mae[0] + 2;
                pq.push_back(p);
            end
            if (de[0]) begin
                if (pq.size() == 0) begin
                    chk("pair_orphan_de", 0, 1, 0);
                end else begin
                    p = pq.pop_front();
                    chk("pair_x", 0, int'(ox[0]), p.x);
                    chk("pair_y", 0, int'(oy[0]), p.y);
                    chk("pair_lead", 0, mae[0], p.t);
                    npairs++;
                end
            end
        end
        if (!madv[0]) froz++;
        if (hprev && !hsd[0]) begin
            if (have_fall) chk("hsd_period", 0, now - last_fall, 1056 + froz);
            last_fall = now; froz = 0; have_fall = 1;
        end
        hprev = hsd[0];
        if (sof[2]) begin
            csof_t.push_back(now);
            csof_c.push_back(int'(cnt_c));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        now++;
        if (go) per_cycle();
    endtask

    task automatic step_to(input int n);
        while (now < n) tick();
    endtask

    initial begin : main
        int hb;
        int exp_c[5];
        exp_c = '{0, 1, 2, 3, 0};
        n_tests = 0; n_fail = 0; now = 0; go = 0; npairs = 0;
        hprev = 1; have_fall = 0; last_fall = 0; froz = 0;
        rstn = 3'b000; en = 3'b000;
        repeat (3) @(negedge clk);
        // Reset state.
        chk("rst_hsd", 0, int'(hsd[0]), 1);
        chk("rst_hsd", 1, int'(hsd[1]), 0);
        chk("rst_vsd", 2, int'(vsd[2]), 1);
        chk("rst_de", 0, int'(de[0]), 0);
        chk("rst_req", 1, int'(req[1]), 0);
        chk("rst_sof", 0, int'(sof[0]), 0);
        chk("rst_cnt", 0, int'(cnt_a), 0);
        rstn = 3'b111; en = 3'b111; go = 1;

        step_to(1);
        chk("a_first_sof", 0, int'(sof[0]), 1);
        chk("a_first_hsd", 0, int'(hsd[0]), 0);
        chk("a_first_vsd", 0, int'(vsd[0]), 0);
        chk("a_first_cnt", 0, int'(cnt_a), 0);
        chk("b_first_sof", 1, int'(sof[1]), 1);
        chk("b_first_hsd", 1, int'(hsd[1]), 1);
        chk("c_first_sof", 2, int'(sof[2]), 1);
        hb = int'(hsd[1]);
        for (int i = 2; i <= 16; i++) begin
            step_to(i);
            hb += int'(hsd[1]);
        end
        chk("b_hsd_high_clocks", 1, hb, 2);
        step_to(30);  chk("a_hsd_h29", 0, int'(hsd[0]), 0);
        step_to(31);  chk("a_hsd_h30", 0, int'(hsd[0]), 1);
        step_to(33);
        chk("b_req_h0", 1, int'(req[1]), 1);
        chk("b_req_x_h0", 1, int'(rx[1]), 0);
        chk("b_req_y_h0", 1, int'(ry[1]), 0);
        chk("b_de_h0", 1, int'(de[1]), 0);
        step_to(37);
        chk("b_de_h4", 1, int'(de[1]), 1);
        chk("b_x_h4", 1, int'(ox[1]), 0);
        chk("b_req_x_h4", 1, int'(rx[1]), 4);
        step_to(96);  chk("b_vbl_before", 1, int'(vbl[1]), 0);
        step_to(97);  chk("b_vbl_v6", 1, int'(vbl[1]), 1);
        step_to(98);  chk("b_vbl_after", 1, int'(vbl[1]), 0);
        step_to(129);
        chk("b_sof_frame2", 1, int'(sof[1]), 1);
        chk("b_cnt_frame2", 1, int'(cnt_b), 1);
        step_to(150);
        en[2] = 1'b0;
        step_to(200);
        #2 rstn[1] = 1'b0;
        #1;
        chk("b_async_rst_hsd", 1, int'(hsd[1]), 0);
        chk("b_async_rst_vsd", 1, int'(vsd[1]), 0);
        chk("b_async_rst_de", 1, int'(de[1]), 0);
        chk("b_async_rst_x", 1, int'(ox[1]), 0);
        chk("b_async_rst_cnt", 1, int'(cnt_b), 0);
        step_to(201);
        rstn[1] = 1'b1;
        step_to(202);
        chk("b_post_rst_sof", 1, int'(sof[1]), 1);
        chk("b_post_rst_cnt", 1, int'(cnt_b), 0);
        step_to(250);
        en[2] = 1'b1;
        step_to(24337);
        chk("a_first_req", 0, int'(req[0]), 1);
        chk("a_first_req_x", 0, int'(rx[0]), 0);
        chk("a_first_req_y", 0, int'(ry[0]), 0);
        chk("a_de_before_first", 0, int'(de[0]), 0);
        step_to(24339);
        chk("a_first_de", 0, int'(de[0]), 1);
        chk("a_first_x", 0, int'(ox[0]), 0);
        chk("a_first_y", 0, int'(oy[0]), 0);
        step_to(25745);
        chk("a_x_h400", 0, int'(ox[0]), 350);
        chk("a_y_v24", 0, int'(oy[0]), 1);
        en[0] = 1'b0;
        step_to(25795);
        chk("a_frozen_x", 0, int'(ox[0]), 350);
        chk("a_frozen_de", 0, int'(de[0]), 1);
        step_to(25845);
        en[0] = 1'b1;
        step_to(25846);
        chk("a_resume_x", 0, int'(ox[0]), 351);
        step_to(26600);

        chk("c_sof_count", 2, (csof_t.size() >= 6) ? 6 : csof_t.size(), 6);
        if (csof_t.size() >= 6) begin
            for (int i = 0; i < 5; i++) begin
                chk("c_cnt_seq", 2, csof_c[i], exp_c[i]);
                chk("c_sof_time", 2, csof_t[i], 32 * i + 1);
            end
            chk("c_frozen_frame_period", 2, csof_t[5] - csof_t[4], 132);
        end
        chk("a_pairs_seen", 0, (npairs >= 1600) ? 1 : 0, 1);
        go = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
